// File: rtl/wb_cmd_formatter.sv
// Host command to Wishbone single-access bridge. A trigger latches one command,
// runs one read or write on the bus, and optionally pushes the read result into
// the host readback FIFO. Sticky status flags record ack timeouts and overruns.
module wb_cmd_formatter #(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 16,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       cmd_word,
   input  logic              cmd_trig,
   output logic              cmd_busy,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [DATA_W-1:0] wb_dat_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              fifo_full,
   output logic              fifo_wr_en,
   output logic [31:0]       fifo_din,
   output logic [31:0]       last_write,
   output logic              timeout_err,
   output logic              overrun_err,
   output logic [1:0]        dbg_state
);

   // Handshake: a command is accepted only when cmd_trig is high while the bridge
   // is idle; the bus access completes on the edge where wb_cyc_o and wb_ack_i are
   // both high; a FIFO word is written on the edge after PUSH sees fifo_full low.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      PUSH = 2'd2
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

   state_t              state, state_n;
   logic                we_q, push_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [7:0]          ack_cnt;
   logic                accept, bus_end, timeout_hit, push_go;
   logic [31:0]         push_word;
   logic                unused_cmd;

   // Only we/push/adr/wdata fields of the command are meaningful.
   assign unused_cmd = ^cmd_word;

   assign wb_stb_o  = wb_cyc_o;
   assign cmd_busy  = (state != IDLE);
   assign dbg_state = state;

   // Readback word: zero-padded with the address above the read data.
   always_comb begin
      push_word                   = '0;
      push_word[16 +: ADDR_W]     = wb_adr_o;
      push_word[DATA_W-1:0]       = rdata_q;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state logic and single-cycle control strobes; ack beats timeout.
   always_comb begin
      state_n     = state;
      accept      = 1'b0;
      bus_end     = 1'b0;
      timeout_hit = 1'b0;
      push_go     = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_trig) begin
               accept  = 1'b1;
               state_n = BUS;
            end
         end
         BUS: begin
            if (wb_ack_i) begin
               bus_end = 1'b1;
               state_n = (!we_q && push_q) ? PUSH : IDLE;
            end else if (ack_cnt == TO_LAST) begin
               bus_end     = 1'b1;
               timeout_hit = 1'b1;
               state_n     = IDLE;
            end
         end
         PUSH: begin
            if (!fifo_full) begin
               push_go = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath: command latch, bus outputs, ack counter, FIFO write and status.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q        <= 1'b0;
         push_q      <= 1'b0;
         rdata_q     <= '0;
         ack_cnt     <= '0;
         wb_cyc_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= '0;
         wb_dat_o    <= '0;
         fifo_wr_en  <= 1'b0;
         fifo_din    <= '0;
         last_write  <= '0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         fifo_wr_en <= 1'b0;
         if (accept) begin
            we_q     <= cmd_word[31];
            push_q   <= cmd_word[30];
            wb_we_o  <= cmd_word[31];
            wb_adr_o <= cmd_word[16 +: ADDR_W];
            wb_dat_o <= cmd_word[DATA_W-1:0];
            wb_cyc_o <= 1'b1;
            ack_cnt  <= '0;
         end
         if (state == BUS && !bus_end) ack_cnt <= ack_cnt + 8'd1;
         if (bus_end) wb_cyc_o <= 1'b0;
         if (state == BUS && wb_ack_i && !we_q) rdata_q <= wb_dat_i;
         if (timeout_hit) timeout_err <= 1'b1;
         if (cmd_trig && state != IDLE) overrun_err <= 1'b1;
         if (push_go) begin
            fifo_wr_en <= 1'b1;
            fifo_din   <= push_word;
            last_write <= push_word;
         end
      end
   end

endmodule

// File: tb/tb_wb_cmd_formatter.sv
// Bench for wb_cmd_formatter: directed scenarios with literal expectations plus
// randomized command traffic against a transaction-level reference model.
module tb_wb_cmd_formatter;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 16;
   localparam int TO     = 12;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [31:0]       cmd_word = '0;
   logic              cmd_trig = 1'b0;
   logic              cmd_busy;
   logic              wb_cyc_o, wb_stb_o, wb_we_o;
   logic [ADDR_W-1:0] wb_adr_o;
   logic [DATA_W-1:0] wb_dat_o;
   logic [DATA_W-1:0] wb_dat_i = '0;
   logic              wb_ack_i = 1'b0;
   logic              fifo_full = 1'b0;
   logic              fifo_wr_en;
   logic [31:0]       fifo_din, last_write;
   logic              timeout_err, overrun_err;
   logic [1:0]        dbg_state;

   int checks = 0;
   int errors = 0;
   int ack_delay = 0;      // -1: slave never acks
   int wait_cnt = 0;
   bit rand_full = 0;
   bit force_full = 0;
   int wr_seen = 0;
   logic [31:0] exp_q[$];

   wb_cmd_formatter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .cmd_word(cmd_word), .cmd_trig(cmd_trig),
      .cmd_busy(cmd_busy), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .last_write(last_write),
      .timeout_err(timeout_err), .overrun_err(overrun_err), .dbg_state(dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Wishbone slave: acks after ack_delay extra cycles of an open cycle.
   always @(negedge clk) begin
      if (wb_cyc_o) begin
         wb_ack_i = (ack_delay >= 0 && wait_cnt == ack_delay);
         wait_cnt++;
      end else begin
         wb_ack_i = 1'b0;
         wait_cnt = 0;
      end
      fifo_full = rand_full ? ($urandom_range(0, 2) == 0) : force_full;
   end

   // Reference model: one transaction in flight, tracked by bus age and a
   // pending-push flag; expected outputs updated from inputs seen at each edge.
   logic              m_busy, m_cyc, m_we, m_push, m_wr, m_to, m_ov;
   logic [ADDR_W-1:0] m_adr;
   logic [DATA_W-1:0] m_wdata, m_rdata;
   logic [31:0]       m_din, m_last, word;
   int                m_age;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_cyc = 0; m_we = 0; m_push = 0; m_wr = 0; m_to = 0; m_ov = 0;
         m_adr = '0; m_wdata = '0; m_rdata = '0; m_din = '0; m_last = '0; m_age = 0;
      end else begin
         m_wr = 0;
         if (m_busy) begin
            if (cmd_trig) m_ov = 1;
            if (m_cyc) begin
               m_age++;
               if (wb_ack_i) begin
                  m_cyc = 0;
                  if (!m_we) m_rdata = wb_dat_i;
                  if (m_we || !m_push) m_busy = 0;
               end else if (m_age == TO) begin
                  m_cyc = 0;
                  m_to = 1;
                  m_busy = 0;
               end
            end else if (!fifo_full) begin
               word = '0;
               word[16 +: ADDR_W] = m_adr;
               word[DATA_W-1:0] = m_rdata;
               m_wr = 1; m_din = word; m_last = word;
               exp_q.push_back(word);
               m_busy = 0;
            end
         end else if (cmd_trig) begin
            m_we = cmd_word[31]; m_push = cmd_word[30];
            m_adr = cmd_word[16 +: ADDR_W]; m_wdata = cmd_word[DATA_W-1:0];
            m_cyc = 1; m_busy = 1; m_age = 0;
         end
      end
   end

   // Compare process: every cycle, shortly after the active edge.
   always @(posedge clk) begin
      #1;
      chk("cyc", wb_cyc_o, m_cyc);
      chk("stb", wb_stb_o, m_cyc);
      chk("busy", cmd_busy, m_busy);
      chk("wr_en", fifo_wr_en, m_wr);
      chk("last_write", last_write, m_last);
      chk("timeout_err", timeout_err, m_to);
      chk("overrun_err", overrun_err, m_ov);
      if (m_cyc) begin
         chk("adr", wb_adr_o, m_adr);
         chk("we", wb_we_o, m_we);
         chk("dat_o", wb_dat_o, m_wdata);
      end
      if (m_wr) chk("fifo_din", fifo_din, m_din);
      if (fifo_wr_en) begin
         wr_seen++;
         if (exp_q.size() == 0) chk("fifo_extra", 32'd1, 32'd0);
         else chk("fifo_order", fifo_din, exp_q.pop_front());
      end
   end

   task automatic issue(input logic [31:0] w);
      cmd_word = w;
      cmd_trig = 1'b1;
      @(negedge clk);
      cmd_trig = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         if (!cmd_busy) return;
         @(negedge clk);
      end
      chk("idle_wait_expired", 32'd1, 32'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_cyc"}, wb_cyc_o, 0);
      chk({tag, "_stb"}, wb_stb_o, 0);
      chk({tag, "_we"}, wb_we_o, 0);
      chk({tag, "_adr"}, wb_adr_o, 0);
      chk({tag, "_dat"}, wb_dat_o, 0);
      chk({tag, "_wr_en"}, fifo_wr_en, 0);
      chk({tag, "_din"}, fifo_din, 0);
      chk({tag, "_last"}, last_write, 0);
      chk({tag, "_busy"}, cmd_busy, 0);
      chk({tag, "_to"}, timeout_err, 0);
      chk({tag, "_ov"}, overrun_err, 0);
   endtask

   initial begin
      int wr0;
      logic [31:0] w;
      // Reset.
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Write: ack on the second bus cycle, no FIFO traffic.
      ack_delay = 1;
      wr0 = wr_seen;
      issue(32'h8005_00A5);
      chk("t1_cyc", wb_cyc_o, 1);
      chk("t1_adr", wb_adr_o, 7'h05);
      chk("t1_we", wb_we_o, 1);
      chk("t1_dat", wb_dat_o, 16'h00A5);
      wait_idle();
      repeat (2) @(negedge clk);
      chk("t1_no_push", wr_seen, wr0);

      // Read with push, immediate ack.
      ack_delay = 0;
      wb_dat_i = 16'hBEEF;
      wr0 = wr_seen;
      issue(32'h4003_0000);
      wait_idle();
      chk("t2_pushes", wr_seen, wr0 + 1);
      chk("t2_last", last_write, 32'h0003_BEEF);

      // Same read with the FIFO full for 10 cycles.
      force_full = 1;
      wb_dat_i = 16'h1234;
      wr0 = wr_seen;
      issue(32'h4003_0000);
      repeat (10) begin
         @(negedge clk);
         chk("t3_busy", cmd_busy, 1);
      end
      chk("t3_stall", wr_seen, wr0);
      force_full = 0;
      wait_idle();
      chk("t3_pushes", wr_seen, wr0 + 1);
      chk("t3_last", last_write, 32'h0003_1234);

      // Timeout, then a normal command.
      ack_delay = -1;
      wr0 = wr_seen;
      issue(32'h4011_0000);
      wait_idle();
      chk("t4_to", timeout_err, 1);
      chk("t4_no_push", wr_seen, wr0);
      ack_delay = 0;
      wb_dat_i = 16'h5A5A;
      issue(32'h4011_0000);
      wait_idle();
      chk("t4_last", last_write, 32'h0011_5A5A);

      // Overrun: second trigger one cycle after the first.
      ack_delay = 2;
      issue(32'h8022_1111);
      issue(32'h8033_2222);
      chk("t5_adr", wb_adr_o, 7'h22);
      wait_idle();
      chk("t5_ov", overrun_err, 1);

      // Reset while the bus cycle is open.
      ack_delay = -1;
      issue(32'h4044_0000);
      repeat (2) @(negedge clk);
      chk("t6_cyc_open", wb_cyc_o, 1);
      rst = 1'b1;
      @(negedge clk);
      check_zero("t6");
      rst = 1'b0;
      ack_delay = 0;
      wb_dat_i = 16'hCAFE;
      issue(32'h4044_0000);
      wait_idle();
      chk("t6_last", last_write, 32'h0044_CAFE);

      // Randomized traffic.
      rand_full = 1;
      for (int n = 0; n < 250; n++) begin
         ack_delay = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 4));
         wb_dat_i = DATA_W'($urandom);
         w = $urandom;
         issue(w);
         if ($urandom_range(0, 7) == 0) begin
            w = $urandom;
            issue(w);
         end
         wait_idle();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rand_full = 0;
      force_full = 0;
      repeat (3) @(negedge clk);
      chk("fifo_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
